// File: rtl/mcu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// mcu_irq_arbiter : edge-captured, round-robin interrupt arbiter on MCU byte bus
// Revision 1.0
// ============================================================================
module mcu_irq_arbiter #(
    parameter int         NUM_SRC    = 4,
    parameter logic [7:0] CMD_STATUS = 8'h00,
    parameter logic [7:0] CMD_ACK    = 8'h01,
    parameter logic [7:0] CMD_MASK   = 8'h02,
    parameter logic [7:0] MASK_RST   = 8'hFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               data_in_strobe,
    input  logic               data_in_start,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic [NUM_SRC-1:0] src_iack,
    output logic               irq
);

    localparam logic [2:0] c_last_rst = 3'(NUM_SRC - 1);
    localparam logic [7:0] c_num_src  = 8'(NUM_SRC);

    logic [NUM_SRC-1:0] r_src_irq_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [2:0]         r_last_grant;
    logic [2:0]         r_sel_idx;
    logic               r_sel_valid;
    logic [3:0]         r_state;
    logic [7:0]         r_command;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [7:0]         w_pend8;
    logic               w_data_byte;
    logic               w_ack_ok;
    logic [2:0]         w_rr_idx;
    logic               w_rr_valid;
    int                 w_rr_c;

    assign w_rise      = src_irq & ~r_src_irq_d;
    assign w_active    = r_pending & r_mask;
    assign w_pend8     = 8'(r_pending);
    assign w_data_byte = data_in_strobe && !data_in_start && (r_state != 4'd0);
    assign w_ack_ok    = w_data_byte && (r_command == CMD_ACK) && (r_state == 4'd1)
                         && (data_in < c_num_src) && w_pend8[data_in[2:0]];
    assign w_ack_clr   = w_ack_ok ? (NUM_SRC'(1) << data_in[2:0]) : '0;

    // Scan downward so the last hit is the candidate closest after last_grant.
    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        w_rr_c     = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_rr_c = (int'(r_last_grant) + 1 + i) % NUM_SRC;
            if (w_active[w_rr_c]) begin
                w_rr_valid = 1'b1;
                w_rr_idx   = 3'(w_rr_c);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out     <= 8'h00;
            src_iack     <= '0;
            irq          <= 1'b0;
            r_src_irq_d  <= '0;
            r_pending    <= '0;
            r_mask       <= MASK_RST[NUM_SRC-1:0];
            r_last_grant <= c_last_rst;
            r_sel_idx    <= '0;
            r_sel_valid  <= 1'b0;
            r_state      <= 4'd0;
            r_command    <= 8'h00;
        end else begin
            r_src_irq_d <= src_irq;
            // A new rising edge wins over an ack clearing the same bit.
            r_pending   <= (r_pending & ~w_ack_clr) | w_rise;
            irq         <= |w_active;
            src_iack    <= w_ack_clr;
            if (w_ack_ok) begin
                r_last_grant <= data_in[2:0];
            end

            if (data_in_strobe && data_in_start) begin
                r_state     <= 4'd1;
                r_command   <= data_in;
                r_sel_idx   <= w_rr_idx;
                r_sel_valid <= w_rr_valid;
            end else if (w_data_byte) begin
                if (r_state != 4'hF) begin
                    r_state <= r_state + 4'd1;
                end
                if (r_command == CMD_STATUS) begin
                    case (r_state)
                        4'd1:    data_out <= {r_sel_valid, 4'b0000, r_sel_idx};
                        4'd2:    data_out <= w_pend8;
                        default: data_out <= 8'h00;
                    endcase
                end
                if ((r_command == CMD_MASK) && (r_state == 4'd1)) begin
                    r_mask <= data_in[NUM_SRC-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcu_irq_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mcu_irq_arbiter : scoreboard bench with a behavioural arbiter model
// Revision 1.0
// ============================================================================
module tb_mcu_irq_arbiter;

    localparam int         N  = 4;
    localparam logic [7:0] ST = 8'h00;
    localparam logic [7:0] AK = 8'h01;
    localparam logic [7:0] MK = 8'h02;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         data_in_strobe;
    logic         data_in_start;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic [N-1:0] src_irq;
    logic [N-1:0] src_iack;
    logic         irq;

    mcu_irq_arbiter #(.NUM_SRC(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .data_out       (data_out),
        .src_irq        (src_irq),
        .src_iack       (src_iack),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           tag;
        logic [7:0]   dout;
        logic [N-1:0] iack;
        logic         irq;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           total = 0;
    int           bad = 0;
    int           cyc_count = 0;
    logic [N-1:0] src_v = '0;

    bit         m_pend[N];
    bit         m_mask[N];
    bit         m_prev[N];
    int         m_last;
    int         m_state;
    logic [7:0] m_cmd;
    int         m_sel;
    bit         m_selv;
    logic [7:0] m_dout;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_count, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
            m_prev[i] = 1'b0;
        end
        m_last  = N - 1;
        m_state = 0;
        m_cmd   = 8'h00;
        m_sel   = 0;
        m_selv  = 1'b0;
        m_dout  = 8'h00;
    endtask

    // Predicts the outputs visible after the next clock edge for these inputs.
    task automatic model_step(bit s, bit st, logic [7:0] d, logic [N-1:0] src);
        exp_t e;
        int   ack = -1;
        bit   any = 1'b0;
        for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) any = 1'b1;
        e.tag  = cyc_count + 1;
        e.irq  = any;
        e.iack = '0;
        if (s && st) begin
            m_cmd   = d;
            m_state = 1;
            m_selv  = 1'b0;
            m_sel   = 0;
            for (int j = 1; j <= N; j++) begin
                int c = (m_last + j) % N;
                if (!m_selv && m_pend[c] && m_mask[c]) begin
                    m_selv = 1'b1;
                    m_sel  = c;
                end
            end
        end else if (s && m_state != 0) begin
            if (m_cmd == ST) begin
                if (m_state == 1) m_dout = (m_selv ? 8'h80 : 8'h00) | 8'(m_sel);
                else if (m_state == 2) begin
                    m_dout = 8'h00;
                    for (int i = 0; i < N; i++) if (m_pend[i]) m_dout[i] = 1'b1;
                end else m_dout = 8'h00;
            end else if (m_cmd == AK && m_state == 1) begin
                if (int'(d) < N && m_pend[int'(d)]) ack = int'(d);
            end else if (m_cmd == MK && m_state == 1) begin
                for (int i = 0; i < N; i++) m_mask[i] = d[i];
            end
            if (m_state < 15) m_state++;
        end
        if (ack >= 0) begin
            m_pend[ack] = 1'b0;
            e.iack[ack] = 1'b1;
            m_last      = ack;
        end
        for (int i = 0; i < N; i++) begin
            if (src[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev[i] = src[i];
        end
        e.dout = m_dout;
        q.push_back(e);
    endtask

    task automatic cyc(bit s, bit st, logic [7:0] d);
        @(posedge clk);
        #1;
        data_in_strobe = s;
        data_in_start  = st;
        data_in        = d;
        src_irq        = src_v;
        model_step(s, st, d, src_v);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        #2;
        reset_n        = 1'b0;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in        = 8'h00;
        src_v          = '0;
        src_irq        = '0;
        #1;
        check("rst_dout", 32'(data_out), 32'h0);
        check("rst_iack", 32'(src_iack), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_step(1'b0, 1'b0, 8'h00, src_v);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tag <= cyc_count) begin
                mon_e = q.pop_front();
                check("dout", 32'(data_out), 32'(mon_e.dout));
                check("iack", 32'(src_iack), 32'(mon_e.iack));
                check("irq", 32'(irq), 32'(mon_e.irq));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset_n        = 1'b0;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in        = 8'h00;
        src_irq        = '0;
        model_reset();
        do_reset();

        // single source raise, status readback
        src_v = 4'b0100; idle(1);
        src_v = 4'b0000; idle(2);
        check("irq_after_rise", 32'(irq), 32'h1);
        cyc(1, 1, ST); cyc(1, 0, 8'h00); idle(1);
        check("status_sel", 32'(data_out), 32'h82);
        cyc(1, 0, 8'h00); idle(1);
        check("status_pend", 32'(data_out), 32'h04);

        // two sources, round robin from last_grant=3
        do_reset();
        src_v = 4'b1001; idle(1);
        src_v = 4'b0000; idle(2);
        cyc(1, 1, ST); cyc(1, 0, 8'h00); idle(1);
        check("rr_first", 32'(data_out), 32'h80);
        cyc(1, 1, AK); cyc(1, 0, 8'h00); idle(1);
        check("ack0_pulse", 32'(src_iack), 32'h1);
        idle(1);
        check("ack0_pulse_end", 32'(src_iack), 32'h0);
        check("ack0_irq_held", 32'(irq), 32'h1);
        cyc(1, 1, ST); cyc(1, 0, 8'h00); idle(1);
        check("rr_second", 32'(data_out), 32'h83);
        cyc(1, 1, AK); cyc(1, 0, 8'h03); idle(2);
        check("ack3_irq_low", 32'(irq), 32'h0);

        // masking
        cyc(1, 1, MK); cyc(1, 0, 8'h0E);
        src_v = 4'b0001; idle(1);
        src_v = 4'b0000; idle(3);
        check("masked_irq", 32'(irq), 32'h0);
        cyc(1, 1, MK); cyc(1, 0, 8'h0F); idle(2);
        check("unmasked_irq", 32'(irq), 32'h1);

        // rejected acks
        cyc(1, 1, AK); cyc(1, 0, 8'h05); idle(1);
        check("ack_oob_none", 32'(src_iack), 32'h0);
        cyc(1, 1, AK); cyc(1, 0, 8'h01); idle(1);
        check("ack_notpend_none", 32'(src_iack), 32'h0);

        // rise coinciding with ack of the same source
        src_v = 4'b0010; idle(1);
        src_v = 4'b0000; idle(2);
        cyc(1, 1, AK);
        src_v = 4'b0010; cyc(1, 0, 8'h01);
        idle(1);
        check("simul_iack", 32'(src_iack), 32'h2);
        idle(1);
        check("simul_irq", 32'(irq), 32'h1);
        src_v = 4'b0000; idle(1);

        // reset during the second status byte, then stray data strobe
        cyc(1, 1, ST); cyc(1, 0, 8'h00); cyc(1, 0, 8'h00);
        do_reset();
        cyc(1, 0, 8'h55); idle(1);
        check("stray_dout", 32'(data_out), 32'h0);
        src_v = 4'b0001; idle(1);
        src_v = 4'b0000; idle(2);
        check("mask_after_rst", 32'(irq), 32'h1);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] d;
            bit s, st;
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, N - 1);
                src_v[k] = ~src_v[k];
            end
            s  = ($urandom_range(0, 9) < 4);
            st = s && ($urandom_range(0, 9) < 3);
            if (st) d = 8'($urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = 8'($urandom_range(0, 7));
            cyc(s, st, d);
        end
        idle(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
